// File: rtl/fir_structs_pkg.sv
// ---------------------------------------------------------------------------
// fir_structs -- shared FIR type and constant definitions.
//
// Holds the coefficient-bank controller state encoding and the default tap
// count and coefficient width used by the FIR coefficient logic.
// ---------------------------------------------------------------------------
package fir_structs;

  localparam int NUM_TAPS_DEF = 24;
  localparam int COEF_W_DEF   = 18;

  typedef enum logic [1:0] {
    CoefIdle     = 2'd0,
    CoefLoading  = 2'd1,
    CoefSwapWait = 2'd2,
    CoefSwap     = 2'd3
  } coef_state_type;

endpackage : fir_structs

// File: rtl/coef_bank.sv
// ---------------------------------------------------------------------------
// coef_bank -- shadow/active coefficient register pair.
//
// The shadow bank takes one coefficient per cycle while wr_en is high.
// copy_en transfers the whole shadow bank into the active bank in one edge,
// so the datapath only ever observes complete coefficient sets.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset, clears both banks
//   wr_en        write shadow[wr_idx] <= wr_data
//   wr_idx       shadow tap index (must be < NUM_TAPS when wr_en is high)
//   wr_data      coefficient value to write
//   copy_en      active <= shadow
//   active_coefs active bank, tap i at bits [i*COEF_W +: COEF_W]
// ---------------------------------------------------------------------------
module coef_bank
  import fir_structs::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [COEF_W-1:0]            wr_data,
  input  logic                         copy_en,
  output logic [NUM_TAPS*COEF_W-1:0]   active_coefs
);

  logic [COEF_W-1:0]          shadow [NUM_TAPS];
  logic [NUM_TAPS*COEF_W-1:0] active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= '0;
    end else if (copy_en) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        active[i*COEF_W +: COEF_W] <= shadow[i];
      end
    end
  end

  assign active_coefs = active;

endmodule : coef_bank

// File: rtl/coef_bank_ctrl.sv
// ---------------------------------------------------------------------------
// coef_bank_ctrl -- double-buffered FIR coefficient bank controller.
//
// Coefficients are pushed one per cycle into a shadow bank. Once every tap
// index has been written at least once, the controller raises coef_hold,
// waits for the datapath to go idle, then copies the shadow bank into the
// active bank in a single cycle.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   PushCoef      coefficient write strobe (one per cycle)
//   CoefIdx       tap index of the pushed coefficient
//   CoefData      pushed coefficient value
//   datapath_busy multiplier/accumulator is mid-sample
//   active_coefs  active bank, tap i at bits [i*COEF_W +: COEF_W]
//   coef_valid    active bank holds a complete set (sticky after first swap)
//   coef_hold     datapath must not start a new sample
//   coef_loading  shadow bank partially loaded
//   load_err      one-cycle pulse after a rejected push
// ---------------------------------------------------------------------------
module coef_bank_ctrl
  import fir_structs::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         PushCoef,
  input  logic [IDX_W-1:0]             CoefIdx,
  input  logic [COEF_W-1:0]            CoefData,
  input  logic                         datapath_busy,
  output logic [NUM_TAPS*COEF_W-1:0]   active_coefs,
  output logic                         coef_valid,
  output logic                         coef_hold,
  output logic                         coef_loading,
  output logic                         load_err
);

  localparam int               CNT_W    = $clog2(NUM_TAPS + 1);
  localparam logic [IDX_W:0]   TAPS_EXT = (IDX_W+1)'(NUM_TAPS);
  localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(NUM_TAPS);

  coef_state_type    state, state_next;
  logic [NUM_TAPS-1:0] loaded_mask;
  logic [CNT_W-1:0]  load_cnt, cnt_next;
  logic              idx_ok, push_ok, push_err, new_tap, do_swap;

  // Only Idle and Loading accept pushes; everything else is an error.
  assign idx_ok   = ({1'b0, CoefIdx} < TAPS_EXT);
  assign push_ok  = PushCoef && idx_ok &&
                    ((state == CoefIdle) || (state == CoefLoading));
  assign push_err = PushCoef && !push_ok;
  // A repeated index overwrites the shadow entry but does not count again.
  assign new_tap  = push_ok && !loaded_mask[CoefIdx];
  assign cnt_next = load_cnt + CNT_W'(new_tap);
  assign do_swap  = (state == CoefSwap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CoefIdle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    coef_hold    = 1'b0;
    coef_loading = 1'b0;
    unique case (state)
      CoefIdle: begin
        if (push_ok) begin
          state_next = (cnt_next == TAPS_CNT) ? CoefSwapWait : CoefLoading;
        end
      end
      CoefLoading: begin
        coef_loading = 1'b1;
        if (push_ok && (cnt_next == TAPS_CNT)) begin
          state_next = CoefSwapWait;
        end
      end
      CoefSwapWait: begin
        coef_hold = 1'b1;
        if (!datapath_busy) begin
          state_next = CoefSwap;
        end
      end
      CoefSwap: begin
        coef_hold  = 1'b1;
        state_next = CoefIdle;
      end
      default: state_next = CoefIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loaded_mask <= '0;
      load_cnt    <= '0;
      coef_valid  <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= push_err;
      if (do_swap) begin
        loaded_mask <= '0;
        load_cnt    <= '0;
        coef_valid  <= 1'b1;
      end else if (push_ok) begin
        loaded_mask[CoefIdx] <= 1'b1;
        load_cnt             <= cnt_next;
      end
    end
  end

  coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .IDX_W    (IDX_W)
  ) u_coef_bank (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (push_ok),
    .wr_idx       (CoefIdx),
    .wr_data      (CoefData),
    .copy_en      (do_swap),
    .active_coefs (active_coefs)
  );

endmodule : coef_bank_ctrl

// File: tb/tb_coef_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coef_bank_ctrl -- directed self-checking bench for coef_bank_ctrl.
// ---------------------------------------------------------------------------
module tb_coef_bank_ctrl;

  localparam int NT = 24;
  localparam int CW = 18;
  localparam int IW = 5;
  localparam int AW = NT * CW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          PushCoef;
  logic [IW-1:0] CoefIdx;
  logic [CW-1:0] CoefData;
  logic          datapath_busy;
  logic [AW-1:0] active_coefs;
  logic          coef_valid;
  logic          coef_hold;
  logic          coef_loading;
  logic          load_err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] set1, set2, set3, set4;

  always #5 clk = ~clk;

  coef_bank_ctrl #(
    .NUM_TAPS (NT),
    .COEF_W   (CW),
    .IDX_W    (IW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .PushCoef      (PushCoef),
    .CoefIdx       (CoefIdx),
    .CoefData      (CoefData),
    .datapath_busy (datapath_busy),
    .active_coefs  (active_coefs),
    .coef_valid    (coef_valid),
    .coef_hold     (coef_hold),
    .coef_loading  (coef_loading),
    .load_err      (load_err)
  );

  function automatic logic [AW-1:0] mk_set(input int base);
    logic [AW-1:0] v;
    v = '0;
    for (int i = 0; i < NT; i++) v[i*CW +: CW] = CW'(base + i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int data);
    PushCoef = 1'b1;
    CoefIdx  = IW'(idx);
    CoefData = CW'(data);
    step();
    PushCoef = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; PushCoef = 1'b0; CoefIdx = '0; CoefData = '0; datapath_busy = 1'b0;
    set1 = mk_set(1);
    set2 = mk_set(100);
    set3 = mk_set(200);
    set3[5*CW +: CW] = CW'(9);
    set4 = mk_set(400);

    // Reset state
    #2;
    chk("rst_active", active_coefs, '0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_hold", coef_hold, 0);
    chk("rst_loading", coef_loading, 0);
    chk("rst_err", load_err, 0);
    step(); step();
    reset_n = 1'b1;

    // First full load, datapath idle
    push(0, 1);
    chk("l1_loading", coef_loading, 1);
    for (int i = 1; i < NT; i++) push(i, i + 1);
    chk("l1_hold_wait", coef_hold, 1);
    chk("l1_loading_off", coef_loading, 0);
    chk("l1_active_pre", active_coefs, '0);
    step();
    chk("l1_hold_swap", coef_hold, 1);
    chk("l1_valid_pre", coef_valid, 0);
    step();
    chk("l1_active", active_coefs, set1);
    chk("l1_valid", coef_valid, 1);
    chk("l1_hold_idle", coef_hold, 0);
    chk("l1_idle", coef_loading, 0);

    // Reload while valid, with datapath busy over the swap window
    for (int i = 0; i < NT - 1; i++) push(i, 100 + i);
    chk("l2_active_old", active_coefs, set1);
    chk("l2_valid_kept", coef_valid, 1);
    datapath_busy = 1'b1;
    push(NT - 1, 100 + NT - 1);
    for (int c = 0; c < 10; c++) begin
      chk("l2_hold_busy", coef_hold, 1);
      if (c == 2) begin
        push(3, 555);
        chk("l2_err_pulse", load_err, 1);
      end else begin
        step();
        if (c == 3) chk("l2_err_clear", load_err, 0);
      end
    end
    chk("l2_active_busy", active_coefs, set1);
    datapath_busy = 1'b0;
    step();
    chk("l2_swap_hold", coef_hold, 1);
    chk("l2_swap_active_old", active_coefs, set1);
    step();
    chk("l2_active_new", active_coefs, set2);
    chk("l2_hold_idle", coef_hold, 0);

    // Out-of-range push in Idle
    push(30, 'h123);
    chk("oor_err", load_err, 1);
    chk("oor_idle_loading", coef_loading, 0);
    chk("oor_idle_hold", coef_hold, 0);
    step();
    chk("oor_err_clear", load_err, 0);

    // Repeated index and out-of-range push during loading
    push(5, 7);
    for (int i = 0; i < 5; i++) push(i, 200 + i);
    push(NT, 'h3ff);
    chk("dup_oor_err", load_err, 1);
    chk("dup_oor_loading", coef_loading, 1);
    for (int i = 6; i < NT - 1; i++) push(i, 200 + i);
    push(5, 9);
    chk("dup_no_swap", coef_hold, 0);
    chk("dup_still_loading", coef_loading, 1);
    push(NT - 1, 200 + NT - 1);
    chk("dup_hold", coef_hold, 1);
    step(); step();
    chk("dup_active", active_coefs, set3);

    // Reset mid-load discards the partial set
    for (int i = 0; i < 12; i++) push(i, 300 + i);
    reset_n = 1'b0;
    #1;
    chk("mrst_active", active_coefs, '0);
    chk("mrst_valid", coef_valid, 0);
    chk("mrst_loading", coef_loading, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < NT; i++) push(i, 400 + i);
    chk("mrst_valid_pre", coef_valid, 0);
    chk("mrst_active_pre", active_coefs, '0);
    step(); step();
    chk("mrst_active_new", active_coefs, set4);
    chk("mrst_valid_post", coef_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_coef_bank_ctrl
